// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared definitions for the SDRAM port arbiter: FSM state encodings, grant
// codes driven on the grant output, the SDRAM byte-address width and the data
// pattern returned to a reader whose access was abandoned by the watchdog.
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

    // SDRAM byte address width (32 MB device)
    localparam int ADDR_W = 25;

    // Read data substituted when the controller never acknowledges
    localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    // Encoding is visible on the grant output, so values are fixed
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LD   = 2'd1,
        GNT_CPU  = 2'd2,
        GNT_CAS  = 2'd3
    } gnt_e;

    // One-hot ack vector {ld, cpu, cas} for a given owner
    function automatic logic [2:0] gnt_ack_vec(input gnt_e g);
        logic [2:0] v;
        v = 3'b000;
        case (g)
            GNT_LD:  v = 3'b100;
            GNT_CPU: v = 3'b010;
            GNT_CAS: v = 3'b001;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sdram_grant_sel.sv
// -----------------------------------------------------------------------------
// sdram_grant_sel
// Picks the next owner of the SDRAM port and keeps the cassette starvation
// counter. Fixed priority loader > CPU > cassette, except that the cassette is
// promoted to the top once it has lost CAS_MAX_WAIT arbitrations in a row.
//
// Ports
//   clk_i      system clock
//   reset_i    synchronous active-high reset, clears the starvation counter
//   arb_en_i   high while the arbiter sits in IDLE (the only place grants or
//              counter updates happen)
//   ld_req_i   loader request
//   cpu_req_i  CPU request
//   cas_req_i  cassette request
//   winner_o   grant code of the winner (GNT_NONE when nothing is pending)
// -----------------------------------------------------------------------------
module sdram_grant_sel
    import sdram_arb_pkg::*;
#(
    parameter int CAS_MAX_WAIT = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       arb_en_i,
    input  logic       ld_req_i,
    input  logic       cpu_req_i,
    input  logic       cas_req_i,
    output logic [1:0] winner_o
);

    localparam int CW = (CAS_MAX_WAIT > 0) ? $clog2(CAS_MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CAS_MAX_WAIT);

    logic [CW-1:0] starv_q, starv_d;
    gnt_e          winner;

    // Starved cassette pre-empts the fixed order; otherwise plain priority
    always_comb begin
        winner = GNT_NONE;
        if (cas_req_i && starv_q == CNT_MAX) begin
            winner = GNT_CAS;
        end else if (ld_req_i) begin
            winner = GNT_LD;
        end else if (cpu_req_i) begin
            winner = GNT_CPU;
        end else if (cas_req_i) begin
            winner = GNT_CAS;
        end
    end

    // Counts grants the cassette lost while waiting. A cassette grant or an
    // idle cycle without a cassette request starts the count over.
    always_comb begin
        starv_d = starv_q;
        if (arb_en_i) begin
            if (!cas_req_i || winner == GNT_CAS) begin
                starv_d = '0;
            end else if ((winner == GNT_LD || winner == GNT_CPU) && starv_q != CNT_MAX) begin
                starv_d = starv_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starv_q <= '0;
        end else begin
            starv_q <= starv_d;
        end
    end

    assign winner_o = winner;

endmodule

// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
// Shares one SDRAM byte port between the ROM/tape loader (write only), the
// Z80 CPU (read/write) and the cassette player (read only). One access is in
// flight at a time; a watchdog abandons accesses the controller never acks.
//
// Ports
//   clk_i, reset_i                 clock, synchronous active-high reset
//   ld_req_i/ld_addr_i/ld_din_i    loader write request (level), address, data
//   ld_ack_o                       loader completion pulse
//   cpu_req_i/cpu_we_i             CPU request (level), 1 = write
//   cpu_addr_i/cpu_din_i           CPU address, write data
//   cpu_dout_o/cpu_ack_o           CPU read data (held), completion pulse
//   cas_req_i/cas_addr_i           cassette read request (level), address
//   cas_dout_o/cas_ack_o           cassette read data (held), completion pulse
//   sd_req_o/sd_we_o               SDRAM request (held until ack/timeout), we
//   sd_addr_o/sd_din_o             SDRAM address, write data
//   sd_dout_i/sd_ack_i             SDRAM read data, completion pulse
//   grant_o                        current owner: 0 none, 1 ld, 2 cpu, 3 cas
//   err_o                          sticky watchdog timeout flag
//
// Access timeline: grant registered in IDLE (c0), WAIT from c1 until sd_ack
// or the watchdog, then DONE for one cycle with the owner's ack high.
// -----------------------------------------------------------------------------
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int CAS_MAX_WAIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,

    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [7:0]        ld_din_i,
    output logic              ld_ack_o,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]        cpu_din_i,
    output logic [7:0]        cpu_dout_o,
    output logic              cpu_ack_o,

    input  logic              cas_req_i,
    input  logic [ADDR_W-1:0] cas_addr_i,
    output logic [7:0]        cas_dout_o,
    output logic              cas_ack_o,

    output logic              sd_req_o,
    output logic              sd_we_o,
    output logic [ADDR_W-1:0] sd_addr_o,
    output logic [7:0]        sd_din_o,
    input  logic [7:0]        sd_dout_i,
    input  logic              sd_ack_i,

    output logic [1:0]        grant_o,
    output logic              err_o
);

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    arb_state_e        state_q;
    gnt_e              grant_q;
    logic [WW-1:0]     wait_q;
    logic              sd_req_q;
    logic              sd_we_q;
    logic [ADDR_W-1:0] sd_addr_q;
    logic [7:0]        sd_din_q;
    logic [7:0]        cpu_dout_q;
    logic [7:0]        cas_dout_q;
    logic              ld_ack_q;
    logic              cpu_ack_q;
    logic              cas_ack_q;
    logic              err_q;

    logic [1:0]        winner_raw;
    gnt_e              winner;
    logic              finish_d;
    logic [7:0]        rd_data_d;
    logic [2:0]        ack_vec_d;

    sdram_grant_sel #(
        .CAS_MAX_WAIT(CAS_MAX_WAIT)
    ) u_grant_sel (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .arb_en_i (state_q == ST_IDLE),
        .ld_req_i (ld_req_i),
        .cpu_req_i(cpu_req_i),
        .cas_req_i(cas_req_i),
        .winner_o (winner_raw)
    );

    assign winner = gnt_e'(winner_raw);

    // An ack in the last watchdog cycle still counts as a normal completion,
    // so the timeout path is only taken when sd_ack is low.
    assign finish_d  = sd_ack_i || (wait_q == WAIT_LAST);
    assign rd_data_d = sd_ack_i ? sd_dout_i : TIMEOUT_FILL;
    assign ack_vec_d = gnt_ack_vec(grant_q);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            // Abandons any access in flight; a late sd_ack lands in IDLE,
            // which never looks at it.
            state_q    <= ST_IDLE;
            grant_q    <= GNT_NONE;
            wait_q     <= '0;
            sd_req_q   <= 1'b0;
            sd_we_q    <= 1'b0;
            sd_addr_q  <= '0;
            sd_din_q   <= '0;
            cpu_dout_q <= '0;
            cas_dout_q <= '0;
            ld_ack_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
            cas_ack_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ld_ack_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            cas_ack_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    wait_q <= '0;
                    if (winner != GNT_NONE) begin
                        // Requester inputs are captured here; later changes
                        // on the owner's inputs do not reach the SDRAM.
                        grant_q  <= winner;
                        sd_req_q <= 1'b1;
                        state_q  <= ST_WAIT;
                        case (winner)
                            GNT_LD: begin
                                sd_we_q   <= 1'b1;
                                sd_addr_q <= ld_addr_i;
                                sd_din_q  <= ld_din_i;
                            end
                            GNT_CPU: begin
                                sd_we_q   <= cpu_we_i;
                                sd_addr_q <= cpu_addr_i;
                                sd_din_q  <= cpu_din_i;
                            end
                            default: begin
                                sd_we_q   <= 1'b0;
                                sd_addr_q <= cas_addr_i;
                                sd_din_q  <= 8'h00;
                            end
                        endcase
                    end
                end

                ST_WAIT: begin
                    if (finish_d) begin
                        sd_req_q <= 1'b0;
                        if (!sd_ack_i) begin
                            err_q <= 1'b1;
                        end
                        if (!sd_we_q) begin
                            if (grant_q == GNT_CPU) cpu_dout_q <= rd_data_d;
                            if (grant_q == GNT_CAS) cas_dout_q <= rd_data_d;
                        end
                        // Acks are raised on entry to DONE so they are high
                        // for exactly the DONE cycle.
                        ld_ack_q  <= ack_vec_d[2];
                        cpu_ack_q <= ack_vec_d[1];
                        cas_ack_q <= ack_vec_d[0];
                        state_q   <= ST_DONE;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end

                ST_DONE: begin
                    grant_q <= GNT_NONE;
                    state_q <= ST_IDLE;
                end

                default: begin
                    grant_q  <= GNT_NONE;
                    sd_req_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign ld_ack_o   = ld_ack_q;
    assign cpu_ack_o  = cpu_ack_q;
    assign cas_ack_o  = cas_ack_q;
    assign cpu_dout_o = cpu_dout_q;
    assign cas_dout_o = cas_dout_q;
    assign sd_req_o   = sd_req_q;
    assign sd_we_o    = sd_we_q;
    assign sd_addr_o  = sd_addr_q;
    assign sd_din_o   = sd_din_q;
    assign grant_o    = grant_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arbiter
// Directed scenarios followed by randomized request mixes. Expected owners,
// latencies and read data come from a small transaction-level model: priority
// rules plus a lost-arbitration tally, an SDRAM responder with programmable
// latency and a fixed address->data function.
// -----------------------------------------------------------------------------
module tb_sdram_port_arbiter;

  localparam int CAS_MAX_WAIT = 4;
  localparam int TIMEOUT      = 64;
  localparam int NO_ACK       = 1000;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ld_req_i,  cpu_req_i, cpu_we_i, cas_req_i;
  logic [24:0] ld_addr_i, cpu_addr_i, cas_addr_i;
  logic [7:0]  ld_din_i,  cpu_din_i;
  logic        ld_ack_o,  cpu_ack_o, cas_ack_o;
  logic [7:0]  cpu_dout_o, cas_dout_o;
  logic        sd_req_o, sd_we_o, sd_ack_i, err_o;
  logic [24:0] sd_addr_o;
  logic [7:0]  sd_din_o, sd_dout_i;
  logic [1:0]  grant_o;

  always #5 clk_i = ~clk_i;

  sdram_port_arbiter #(.CAS_MAX_WAIT(CAS_MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_din_i(ld_din_i), .ld_ack_o(ld_ack_o),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_din_i(cpu_din_i), .cpu_dout_o(cpu_dout_o), .cpu_ack_o(cpu_ack_o),
    .cas_req_i(cas_req_i), .cas_addr_i(cas_addr_i), .cas_dout_o(cas_dout_o), .cas_ack_o(cas_ack_o),
    .sd_req_o(sd_req_o), .sd_we_o(sd_we_o), .sd_addr_o(sd_addr_o), .sd_din_o(sd_din_o),
    .sd_dout_i(sd_dout_i), .sd_ack_i(sd_ack_i), .grant_o(grant_o), .err_o(err_o)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int lat       = 0;
  int resp_cnt  = 0;
  bit resp_en   = 1'b1;
  int m_starv   = 0;   // model: arbitrations the cassette has lost in a row
  bit m_err     = 1'b0;
  int obs_grant = 0;
  int grant_cyc = 0;

  // SDRAM contents as seen by readers
  function automatic logic [7:0] rd_fn(input logic [24:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ {7'b0, a[24]} ^ 8'h78;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge. The SDRAM model
  // answers sd_req after `lat` cycles in WAIT (0 = same cycle sd_req is seen).
  task automatic tick();
    @(posedge clk_i); #1;
    cyc++;
    if (sd_req_o && resp_en) begin
      sd_ack_i  = (resp_cnt == lat);
      sd_dout_i = (resp_cnt == lat) ? rd_fn(sd_addr_o) : 8'h00;
      resp_cnt++;
    end else begin
      sd_ack_i  = 1'b0;
      sd_dout_i = 8'h00;
      resp_cnt  = 0;
    end
  endtask

  task automatic reraise(input int w);
    case (w)
      1: begin ld_req_i = 1'b1; ld_addr_i = 25'($urandom); ld_din_i = 8'($urandom); end
      2: begin cpu_req_i = 1'b1; cpu_addr_i = 25'($urandom); cpu_din_i = 8'($urandom);
               cpu_we_i = 1'($urandom); end
      3: begin cas_req_i = 1'b1; cas_addr_i = 25'($urandom); end
      default: ;
    endcase
  endtask

  // Runs one arbitration from an IDLE cycle to the cycle after the ack.
  task automatic run_access(input int lat_i, input bit again, output int w_o);
    int w; int n; bit got; bit to;
    logic [24:0] ea; logic ewe; logic [7:0] edin; logic [7:0] ed; logic [2:0] eack;
    if (cas_req_i && m_starv == CAS_MAX_WAIT) w = 3;
    else if (ld_req_i)  w = 1;
    else if (cpu_req_i) w = 2;
    else if (cas_req_i) w = 3;
    else w = 0;
    case (w)
      1: begin ea = ld_addr_i;  ewe = 1'b1;     edin = ld_din_i;  eack = 3'b100; end
      2: begin ea = cpu_addr_i; ewe = cpu_we_i; edin = cpu_din_i; eack = 3'b010; end
      default: begin ea = cas_addr_i; ewe = 1'b0; edin = 8'h00; eack = 3'b001; end
    endcase
    if (!cas_req_i || w == 3) m_starv = 0;
    else if (m_starv < CAS_MAX_WAIT) m_starv++;
    lat = lat_i; resp_en = (lat_i < NO_ACK); to = (lat_i >= TIMEOUT);

    tick();
    grant_cyc = cyc;
    obs_grant = int'(grant_o);
    chk("grant", grant_o, w);
    chk("sd_req_rise", sd_req_o, 1);
    chk("sd_addr", sd_addr_o, ea);
    chk("sd_we", sd_we_o, ewe);
    if (ewe) chk("sd_din", sd_din_o, edin);
    // owner's inputs wander after grant; the SDRAM side must not follow
    case (w)
      1: ld_addr_i = 25'($urandom);
      2: cpu_addr_i = 25'($urandom);
      default: cas_addr_i = 25'($urandom);
    endcase

    got = 1'b0; n = 1;
    while (!got && n < TIMEOUT + 20) begin
      tick(); n++;
      if (ld_ack_o | cpu_ack_o | cas_ack_o) got = 1'b1;
      else if (sd_req_o) chk("sd_hold", {sd_we_o, sd_addr_o}, {ewe, ea});
    end
    chk("ack_seen", got, 1);
    chk("ack_cycle", n, 2 + (to ? TIMEOUT - 1 : lat_i));
    chk("ack_vec", {ld_ack_o, cpu_ack_o, cas_ack_o}, eack);
    chk("sd_req_drop", sd_req_o, 0);
    ed = to ? 8'hFF : rd_fn(ea);
    if (w == 2 && !ewe) chk("cpu_dout", cpu_dout_o, ed);
    if (w == 3) chk("cas_dout", cas_dout_o, ed);
    if (to) m_err = 1'b1;
    chk("err", err_o, m_err);
    case (w)
      1: ld_req_i = 1'b0;
      2: cpu_req_i = 1'b0;
      default: cas_req_i = 1'b0;
    endcase

    tick();
    chk("ack_pulse", {ld_ack_o, cpu_ack_o, cas_ack_o}, 3'b000);
    chk("grant_idle", grant_o, 0);
    if (w == 2 && !ewe) chk("cpu_dout_hold", cpu_dout_o, ed);
    if (again) reraise(w);
    w_o = w;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    ld_req_i = 0; cpu_req_i = 0; cas_req_i = 0; cpu_we_i = 0;
    ld_addr_i = '0; cpu_addr_i = '0; cas_addr_i = '0; ld_din_i = '0; cpu_din_i = '0;
    resp_en = 1'b0;
    tick(); tick();
    chk("reset_outputs",
        {ld_ack_o, cpu_ack_o, cas_ack_o, sd_req_o, sd_we_o, sd_addr_o, sd_din_o,
         cpu_dout_o, cas_dout_o, grant_o, err_o}, '0);
    reset_i = 1'b0; m_starv = 0; m_err = 1'b0;
    tick();
  endtask

  initial begin
    int w; int prev; int exp_seq[10];
    sd_ack_i = 1'b0; sd_dout_i = 8'h00;
    do_reset();

    // single CPU read, SDRAM answers 3 cycles into WAIT
    cpu_addr_i = 25'h00123; cpu_we_i = 1'b0; cpu_req_i = 1'b1;
    run_access(3, 1'b0, w);
    tick(); tick(); tick();
    chk("cpu_dout_5a", cpu_dout_o, 8'h5A);

    // everyone at once: loader, CPU, cassette
    ld_req_i = 1; ld_addr_i = 25'h0000100; ld_din_i = 8'hC3;
    cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 25'h0000200; cpu_din_i = 8'h3C;
    cas_req_i = 1; cas_addr_i = 25'h1F00300;
    for (int i = 0; i < 3; i++) begin
      run_access(1, 1'b0, w);
      chk("prio_order", obs_grant, i + 1);
    end

    // starvation guard: CPU and cassette always pending
    exp_seq = '{2, 2, 2, 2, 3, 2, 2, 2, 2, 3};
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 25'h0004000;
    cas_req_i = 1; cas_addr_i = 25'h0800000;
    for (int i = 0; i < 10; i++) begin
      run_access(int'($urandom_range(0, 2)), 1'b1, w);
      chk("starve_seq", obs_grant, exp_seq[i]);
    end
    cpu_req_i = 0; cas_req_i = 0; m_starv = 0;
    tick();

    // ack in the very last watchdog cycle still completes cleanly
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 25'h0ABCDEF;
    run_access(TIMEOUT - 1, 1'b0, w);

    // watchdog: cassette read never acknowledged
    cas_req_i = 1; cas_addr_i = 25'h0123456;
    run_access(NO_ACK, 1'b0, w);
    chk("cas_dout_ff", cas_dout_o, 8'hFF);
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 25'h0000777;
    run_access(0, 1'b0, w);
    chk("err_sticky", err_o, 1);

    // reset two cycles after grant, then a stray ack in IDLE
    cas_req_i = 1; cas_addr_i = 25'h1ABCDE; resp_en = 0; lat = 0;
    tick();
    chk("rst_wait_grant", grant_o, 3);
    tick();
    reset_i = 1'b1; cas_req_i = 1'b0;
    tick();
    chk("rst_abandon", {sd_req_o, grant_o, ld_ack_o, cpu_ack_o, cas_ack_o}, '0);
    chk("rst_err_clr", {err_o, cpu_dout_o, cas_dout_o}, '0);
    reset_i = 1'b0; m_err = 1'b0; m_starv = 0;
    tick();
    sd_ack_i = 1'b1; sd_dout_i = 8'h33;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_ack", {sd_req_o, grant_o, ld_ack_o, cpu_ack_o, cas_ack_o, cas_dout_o}, '0);
    end

    // back-to-back loader writes, zero-latency SDRAM
    ld_req_i = 1; ld_addr_i = 25'h0010000; ld_din_i = 8'h11;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      run_access(0, i < 4, w);
      if (i > 0) chk("b2b_period", grant_cyc - prev, 3);
      prev = grant_cyc;
    end

    // random request mixes
    for (int r = 0; r < 25; r++) begin
      ld_req_i = 1'($urandom); cpu_req_i = 1'($urandom); cas_req_i = 1'($urandom);
      if (!(ld_req_i | cpu_req_i | cas_req_i)) cpu_req_i = 1;
      ld_din_i = 8'($urandom); cpu_din_i = 8'($urandom); cpu_we_i = 1'($urandom);
      for (int k = 0; k < 8 && (ld_req_i | cpu_req_i | cas_req_i); k++) begin
        if (ld_req_i)  ld_addr_i  = 25'($urandom);
        if (cpu_req_i) cpu_addr_i = 25'($urandom);
        if (cas_req_i) cas_addr_i = 25'($urandom);
        run_access(int'($urandom_range(0, 4)), (k < 5) && 1'($urandom), w);
      end
      ld_req_i = 0; cpu_req_i = 0; cas_req_i = 0; m_starv = 0;
      tick(); tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "simulation time budget exhausted");
  end

endmodule
